// File: rtl/rng_sched_pkg.sv
// Shared types and defaults for the random-port scheduler.
package rng_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h80200003;
    localparam logic [31:0] DEFAULT_SEED = 32'h00000001;

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR. Advances only when asked; a zero seed would
// lock the register at zero forever, so it is replaced by 1.
module lfsr_galois #(
    parameter int                WIDTH = 32,
    parameter logic [WIDTH-1:0]  POLY  = WIDTH'(32'h80200003),
    parameter logic [WIDTH-1:0]  SEED  = WIDTH'(32'h00000001)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] SEED_SAFE = (SEED == '0) ? WIDTH'(1) : SEED;

    // Shift right, folding the feedback mask in when the outgoing bit is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEED_SAFE;
        end else if (advance) begin
            state <= (state >> 1) ^ (state[0] ? POLY : '0);
        end
    end

endmodule

// File: rtl/rng_port_scheduler.sv
// Round-robin distributor of LFSR words onto NUM_PORTS registered outputs,
// paced by a reloadable period counter and gated by enable/hold.
//
// Handshake-free interface: enable/hold/period/port_mask are level inputs
// sampled every rising edge; port_update is a one-cycle pulse that marks the
// same edge on which the matching port_data slice changes.
module rng_port_scheduler
    import rng_sched_pkg::*;
#(
    parameter int                NUM_PORTS = 4,
    parameter int                WIDTH     = 32,
    parameter int                PERIOD_W  = 8,
    parameter logic [WIDTH-1:0]  POLY      = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0]  SEED      = WIDTH'(DEFAULT_SEED),
    localparam int               IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       hold,
    input  logic [PERIOD_W-1:0]        period,
    input  logic [NUM_PORTS-1:0]       port_mask,
    output logic [NUM_PORTS*WIDTH-1:0] port_data,
    output logic [NUM_PORTS-1:0]       port_update,
    output logic [IDX_W-1:0]           last_port,
    output logic                       busy
);

    sched_state_t         state;
    sched_state_t         next_state;
    logic                 step;
    logic                 load_cnt;
    logic                 update_evt;
    logic [PERIOD_W-1:0]  cnt;
    logic [WIDTH-1:0]     lfsr_word;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     cand;

    lfsr_galois #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (step),
        .state   (lfsr_word)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and step strobe; enable dominates hold, and leaving HOLD
    // spends one cycle without stepping.
    always_comb begin
        next_state = state;
        step       = 1'b0;
        load_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = RUN;
                    load_cnt   = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (hold) begin
                    next_state = HOLD;
                end else begin
                    step = 1'b1;
                end
            end
            HOLD: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (!hold) begin
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign update_evt = step && (cnt == '0);
    assign busy       = (state != IDLE);

    // Pick the first enabled port after last_port, wrapping; last_port itself
    // is the final candidate so a single enabled port is reselected.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = last_port;
        cand      = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand = IDX_W'((int'(last_port) + off) % NUM_PORTS);
            if (!sel_found && port_mask[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Period counter: loaded on entry to RUN, reloaded from period on each
    // update event, otherwise counts down while stepping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load_cnt) begin
            cnt <= period;
        end else if (step) begin
            cnt <= (cnt == '0) ? period : cnt - PERIOD_W'(1);
        end
    end

    // Output registers: write the pre-advance word into the selected port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_data   <= '0;
            port_update <= '0;
            last_port   <= IDX_W'(NUM_PORTS - 1);
        end else begin
            port_update <= '0;
            if (update_evt && sel_found) begin
                port_data[int'(sel_idx)*WIDTH +: WIDTH] <= lfsr_word;
                port_update <= NUM_PORTS'(1) << sel_idx;
                last_port   <= sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_rng_port_scheduler.sv
// Bench for rng_port_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the scheduling rules.
module tb_rng_port_scheduler;

    localparam int NP = 4;
    localparam int W  = 32;
    localparam int PW = 8;
    localparam logic [31:0] POLY = 32'h80200003;
    localparam logic [31:0] SEED = 32'h00000001;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              hold;
    logic [PW-1:0]     period;
    logic [NP-1:0]     port_mask;
    logic [NP*W-1:0]   port_data;
    logic [NP-1:0]     port_update;
    logic [1:0]        last_port;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    rng_port_scheduler #(
        .NUM_PORTS (NP),
        .WIDTH     (W),
        .PERIOD_W  (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .hold        (hold),
        .period      (period),
        .port_mask   (port_mask),
        .port_data   (port_data),
        .port_update (port_update),
        .last_port   (last_port),
        .busy        (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The random word stream is the LFSR sequence indexed by how many steps
    // have been taken; the schedule is expressed as mode/countdown/steps.
    logic [31:0] seq_q[$];
    int          m_mode;      // 0 idle, 1 running, 2 frozen
    int          m_cnt;
    int          m_steps;
    logic [31:0] m_data [NP];
    logic [NP-1:0] m_upd;
    int          m_last;

    function automatic logic [31:0] word_at(input int n);
        logic [31:0] s;
        if (seq_q.size() == 0) seq_q.push_back(SEED);
        while (seq_q.size() <= n) begin
            s = seq_q[seq_q.size()-1];
            seq_q.push_back((s >> 1) ^ (s[0] ? POLY : 32'h0));
        end
        return seq_q[n];
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_cnt   = 0;
        m_steps = 0;
        m_upd   = '0;
        m_last  = NP - 1;
        for (int i = 0; i < NP; i++) m_data[i] = '0;
    endtask

    task automatic model_edge();
        int sel;
        m_upd = '0;
        if (m_mode == 0) begin
            if (enable) begin
                m_mode = 1;
                m_cnt  = int'(period);
            end
        end else if (!enable) begin
            m_mode = 0;
        end else if (m_mode == 2) begin
            if (!hold) m_mode = 1;
        end else if (hold) begin
            m_mode = 2;
        end else begin
            if (m_cnt == 0) begin
                sel = -1;
                for (int k = 1; k <= NP; k++)
                    if (sel < 0 && port_mask[(m_last + k) % NP]) sel = (m_last + k) % NP;
                if (sel >= 0) begin
                    m_data[sel] = word_at(m_steps);
                    m_upd[sel]  = 1'b1;
                    m_last      = sel;
                end
                m_cnt = int'(period);
            end else begin
                m_cnt = m_cnt - 1;
            end
            m_steps++;
        end
    endtask

    // compare process: advance the model at each edge, check just after it
    always @(posedge clk) begin
        if (reset) model_reset();
        else       model_edge();
        #1;
        check("port_data",   128'(port_data),   {m_data[3], m_data[2], m_data[1], m_data[0]});
        check("port_update", 128'(port_update), 128'(m_upd));
        check("last_port",   128'(last_port),   128'(m_last));
        check("busy",        128'(busy),        128'(m_mode != 0));
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int pulse_idx(input logic [NP-1:0] u);
        for (int i = 0; i < NP; i++) if (u[i]) return i;
        return -1;
    endfunction

    // ---------------- stimulus ----------------
    logic [31:0] t2_exp [3];
    logic [NP-1:0] t2_upd [3];
    int t3_exp [3];
    int t3_seen[$];

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        hold = 1'b0;
        period = '0;
        port_mask = 4'hF;
        t2_exp[0] = 32'h00000001; t2_exp[1] = 32'h80200003; t2_exp[2] = 32'hC0300002;
        t2_upd[0] = 4'b0001;      t2_upd[1] = 4'b0010;      t2_upd[2] = 4'b0100;
        t3_exp[0] = 0; t3_exp[1] = 2; t3_exp[2] = 0;

        idle_cycles(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_port_data", 128'(port_data), 128'h0);
        check("rst_last_port", 128'(last_port), 128'd3);
        check("rst_busy",      128'(busy),      128'd0);

        // T2: one update per cycle, literal LFSR words
        period = 8'd0;
        port_mask = 4'hF;
        enable = 1'b1;
        @(posedge clk);  // E0
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2;
            check("t2_word",  128'(port_data[k*W +: W]), 128'(t2_exp[k]));
            check("t2_pulse", 128'(port_update),         128'(t2_upd[k]));
        end
        idle_cycles(6);

        // T3: period 3, ports 0 and 2 only, from a fresh reset
        do_reset();
        period = 8'd3;
        port_mask = 4'b0101;
        enable = 1'b1;
        @(posedge clk);  // E0
        for (int c = 0; c < 13; c++) begin
            @(posedge clk);
            #2;
            if (port_update != '0) t3_seen.push_back(pulse_idx(port_update));
        end
        check("t3_npulses", 128'(t3_seen.size()), 128'd3);
        for (int i = 0; i < 3; i++)
            check("t3_order", 128'(i < t3_seen.size() ? t3_seen[i] : -1), 128'(t3_exp[i]));
        check("t3_port1", 128'(port_data[1*W +: W]), 128'h0);
        check("t3_port3", 128'(port_data[3*W +: W]), 128'h0);

        // T4: hold for 5 cycles mid-count
        @(negedge clk);
        period = 8'd5;
        port_mask = 4'hF;
        idle_cycles(3);
        hold = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_no_pulse", 128'(port_update), 128'h0);
        end
        hold = 1'b0;
        idle_cycles(20);

        // T5: mask off at period 0, then only port 3
        period = 8'd0;
        port_mask = 4'b0000;
        idle_cycles(1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("t5_no_pulse", 128'(port_update), 128'h0);
        end
        port_mask = 4'b1000;
        idle_cycles(4);
        check("t5_last", 128'(last_port), 128'd3);

        // T6: drop enable, outputs hold, then resume without reseed
        port_mask = 4'hF;
        period = 8'd1;
        idle_cycles(4);
        enable = 1'b0;
        idle_cycles(1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t6_busy",  128'(busy),        128'd0);
            check("t6_pulse", 128'(port_update), 128'h0);
        end
        enable = 1'b1;
        idle_cycles(10);

        // T1: asynchronous reset in the middle of a running cycle
        period = 8'd0;
        idle_cycles(3);
        #3;
        reset = 1'b1;
        #1;
        check("t1_port_data",   128'(port_data),   128'h0);
        check("t1_port_update", 128'(port_update), 128'h0);
        check("t1_busy",        128'(busy),        128'd0);
        check("t1_last_port",   128'(last_port),   128'd3);
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            if ($urandom_range(0, 9) == 0)  hold = ~hold;
            if ($urandom_range(0, 24) == 0) period = PW'($urandom_range(0, 4));
            if ($urandom_range(0, 14) == 0) port_mask = NP'($urandom_range(0, 15));
            reset = ($urandom_range(0, 499) == 0);
        end
        reset = 1'b0;
        idle_cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
